// File: rtl/brat_checkpoint.sv
// Branch checkpoint store (BRAT). It snapshots the rename map table's
// next-state tags and ready bits for every dispatched branch, and keeps the
// snapshot ready bits current from the CDB. On a mispredict it restores the
// snapshot and squashes the younger checkpoints. On a correct resolve it
// frees the entry.
module brat_checkpoint #(
    parameter int ARCH_REGS  = 32,
    parameter int PHYS_TAG_W = 6,
    parameter int DEPTH      = 4,
    parameter int ID_W       = $clog2(DEPTH)
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            alloc_req,
    input  logic [ARCH_REGS*PHYS_TAG_W-1:0] snap_value_in,
    input  logic [ARCH_REGS-1:0]            snap_ready_in,
    input  logic                            cdb_valid,
    input  logic [PHYS_TAG_W-1:0]           cdb_tag,
    input  logic                            resolve_valid,
    input  logic                            resolve_mispredict,
    input  logic [ID_W-1:0]                 resolve_id,
    output logic [ID_W-1:0]                 alloc_id,
    output logic                            brat_full,
    output logic [$clog2(DEPTH+1)-1:0]      brat_count,
    output logic                            restore_valid,
    output logic [ARCH_REGS*PHYS_TAG_W-1:0] restore_value_out,
    output logic [ARCH_REGS-1:0]            restore_ready_out,
    output logic [DEPTH-1:0]                squash_mask
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]                                 r_valid;
    logic [ID_W-1:0]                                  r_tail;
    logic [DEPTH-1:0][ARCH_REGS-1:0][PHYS_TAG_W-1:0]  r_value;
    logic [DEPTH-1:0][ARCH_REGS-1:0]                  r_ready;

    logic                  w_full;
    logic [CNT_W-1:0]      w_count;
    logic                  w_mispredict;
    logic                  w_correct;
    logic                  w_alloc;
    logic [ID_W-1:0]       w_dist;
    logic [ID_W-1:0]       w_off;
    logic [DEPTH-1:0]      w_span;
    logic [ARCH_REGS-1:0]  w_hit;

    // Occupancy status from registered state only.
    always_comb begin
        w_full  = r_valid[r_tail];
        w_count = '0;
        for (int unsigned e = 0; e < DEPTH; e++) begin
            w_count = w_count + CNT_W'(r_valid[e]);
        end
    end

    // Decode the resolve and allocation events for this cycle.
    always_comb begin
        w_mispredict = resolve_valid & resolve_mispredict & r_valid[resolve_id];
        w_correct    = resolve_valid & ~resolve_mispredict & r_valid[resolve_id];
        w_alloc      = alloc_req & ~w_full & ~w_mispredict;
    end

    // Circular range resolve_id .. tail-1. If the tail equals resolve_id
    // while that entry is valid, the ring is full and the resolving entry
    // is the oldest one, so every entry is squashed.
    always_comb begin
        w_dist = r_tail - resolve_id;
        w_off  = '0;
        w_span = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            w_off     = ID_W'(i) - resolve_id;
            w_span[i] = (w_dist == '0) || (w_off < w_dist);
        end
    end

    // Same-cycle CDB forwarding for the restored snapshot.
    always_comb begin
        w_hit = '0;
        for (int unsigned r = 0; r < ARCH_REGS; r++) begin
            w_hit[r] = cdb_valid && (r_value[resolve_id][r] == cdb_tag);
        end
    end

    assign alloc_id          = r_tail;
    assign brat_full         = w_full;
    assign brat_count        = w_count;
    assign restore_valid     = w_mispredict;
    assign restore_value_out = w_mispredict ? r_value[resolve_id] : '0;
    assign restore_ready_out = w_mispredict ? (r_ready[resolve_id] | w_hit) : '0;
    assign squash_mask       = w_mispredict ? w_span : '0;

    // Checkpoint storage, valid bits and tail pointer.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= '0;
            r_tail  <= '0;
            r_value <= '0;
            r_ready <= '0;
        end else begin
            for (int unsigned e = 0; e < DEPTH; e++) begin
                for (int unsigned r = 0; r < ARCH_REGS; r++) begin
                    if (cdb_valid && r_valid[e] && (r_value[e][r] == cdb_tag)) begin
                        r_ready[e][r] <= 1'b1;
                    end
                end
            end
            // The later write takes precedence, so the entry being allocated
            // gets snap_ready_in untouched by the CDB update above.
            if (w_alloc) begin
                r_value[r_tail] <= snap_value_in;
                r_ready[r_tail] <= snap_ready_in;
                r_valid[r_tail] <= 1'b1;
                r_tail          <= r_tail + 1'b1;
            end
            if (w_correct) begin
                r_valid[resolve_id] <= 1'b0;
            end
            if (w_mispredict) begin
                r_valid <= r_valid & ~w_span;
                r_tail  <= resolve_id;
            end
        end
    end

endmodule

// File: tb/tb_brat_checkpoint.sv
// Scoreboard bench for brat_checkpoint. The stimulus queues the expected
// status for each cycle and the expected restore contents for each
// mispredict. The monitor pops and compares these records on the falling
// edge.
module tb_brat_checkpoint;

    localparam int AR = 32;
    localparam int TW = 6;
    localparam int D  = 4;

    logic                clock;
    logic                reset;
    logic                alloc_req;
    logic [AR*TW-1:0]    snap_value_in;
    logic [AR-1:0]       snap_ready_in;
    logic                cdb_valid;
    logic [TW-1:0]       cdb_tag;
    logic                resolve_valid;
    logic                resolve_mispredict;
    logic [1:0]          resolve_id;
    logic [1:0]          alloc_id;
    logic                brat_full;
    logic [2:0]          brat_count;
    logic                restore_valid;
    logic [AR*TW-1:0]    restore_value_out;
    logic [AR-1:0]       restore_ready_out;
    logic [D-1:0]        squash_mask;

    brat_checkpoint #(.ARCH_REGS(AR), .PHYS_TAG_W(TW), .DEPTH(D)) dut (
        .clock(clock),
        .reset(reset),
        .alloc_req(alloc_req),
        .snap_value_in(snap_value_in),
        .snap_ready_in(snap_ready_in),
        .cdb_valid(cdb_valid),
        .cdb_tag(cdb_tag),
        .resolve_valid(resolve_valid),
        .resolve_mispredict(resolve_mispredict),
        .resolve_id(resolve_id),
        .alloc_id(alloc_id),
        .brat_full(brat_full),
        .brat_count(brat_count),
        .restore_valid(restore_valid),
        .restore_value_out(restore_value_out),
        .restore_ready_out(restore_ready_out),
        .squash_mask(squash_mask)
    );

    typedef struct {
        int         cyc;
        string      name;
        logic [1:0] aid;
        logic       full;
        logic [2:0] cnt;
        logic       rv;
        logic [3:0] sq;
    } st_t;

    typedef struct {
        string            name;
        logic [AR*TW-1:0] value;
        logic [AR-1:0]    ready;
        logic [3:0]       sq;
    } rs_t;

    st_t st_q[$];
    rs_t rs_q[$];
    int  cyc   = 0;
    int  tests = 0;
    int  fails = 0;
    bit  done  = 0;

    initial clock = 0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, required finish before 100000");
        $fatal(1, "timeout");
    end

    // Snapshot k: reg 5 holds tag 37 for k=0 and tag 40+k otherwise.
    // Every other reg r holds tag r+k.
    function automatic logic [AR*TW-1:0] snap_val(input int k);
        logic [AR*TW-1:0] v;
        v = '0;
        for (int r = 0; r < AR; r++) begin
            if (r == 5) v[r*TW +: TW] = (k == 0) ? 6'd37 : 6'(40 + k);
            else        v[r*TW +: TW] = 6'(r + k);
        end
        return v;
    endfunction

    function automatic logic [AR-1:0] snap_rdy(input int k);
        logic [AR-1:0] v;
        if (k == 0) v = 32'h0000_00DF;
        else        v = 32'hFFFF_0000 | 32'(k);
        return v;
    endfunction

    task automatic idle();
        reset              = 0;
        alloc_req          = 0;
        snap_value_in      = '0;
        snap_ready_in      = '0;
        cdb_valid          = 0;
        cdb_tag            = '0;
        resolve_valid      = 0;
        resolve_mispredict = 0;
        resolve_id         = '0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        idle();
    endtask

    task automatic alloc(input int k);
        alloc_req     = 1;
        snap_value_in = snap_val(k);
        snap_ready_in = snap_rdy(k);
    endtask

    task automatic resolve(input int id, input bit mp);
        resolve_valid      = 1;
        resolve_mispredict = mp;
        resolve_id         = 2'(id);
    endtask

    task automatic exp_st(input string nm, input int aid, input bit full, input int cnt,
                          input bit rv, input logic [3:0] sqm);
        st_t s;
        s.cyc = cyc; s.name = nm; s.aid = 2'(aid); s.full = full;
        s.cnt = 3'(cnt); s.rv = rv; s.sq = sqm;
        st_q.push_back(s);
    endtask

    task automatic exp_rs(input string nm, input int k, input logic [AR-1:0] rdy,
                          input logic [3:0] sqm);
        rs_t r;
        r.name = nm; r.value = snap_val(k); r.ready = rdy; r.sq = sqm;
        rs_q.push_back(r);
    endtask

    // Monitor: compares restore records whenever restore_valid is high, and
    // compares status records whose cycle has arrived.
    always @(negedge clock) begin
        st_t s;
        rs_t r;
        if (restore_valid === 1'b1) begin
            tests++;
            if (rs_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_restore: got restore_valid=1 at cycle %0d, required 0", cyc);
            end else begin
                r = rs_q.pop_front();
                if (restore_value_out !== r.value || restore_ready_out !== r.ready ||
                    squash_mask !== r.sq) begin
                    fails++;
                    $display("FAIL %s: got value=%h ready=%h squash=%b, required value=%h ready=%h squash=%b",
                             r.name, restore_value_out, restore_ready_out, squash_mask,
                             r.value, r.ready, r.sq);
                end
            end
        end
        while (st_q.size() > 0 && st_q[0].cyc <= cyc) begin
            s = st_q.pop_front();
            tests++;
            if (s.cyc != cyc || alloc_id !== s.aid || brat_full !== s.full ||
                brat_count !== s.cnt || restore_valid !== s.rv || squash_mask !== s.sq ||
                (!s.rv && (restore_value_out !== '0 || restore_ready_out !== '0))) begin
                fails++;
                $display("FAIL %s: got id=%0d full=%b cnt=%0d rv=%b sq=%b vz=%b rz=%b, required id=%0d full=%b cnt=%0d rv=%b sq=%b",
                         s.name, alloc_id, brat_full, brat_count, restore_valid, squash_mask,
                         restore_value_out == '0, restore_ready_out == '0,
                         s.aid, s.full, s.cnt, s.rv, s.sq);
            end
        end
        if (done) begin
            while (rs_q.size() > 0) begin
                r = rs_q.pop_front();
                tests++;
                fails++;
                $display("FAIL %s: got no restore, required restore_valid=1", r.name);
            end
            $display("[TB] %0d tests run, %0d failed", tests, fails);
            $finish;
        end
    end

    initial begin
        idle();
        reset = 1;
        @(posedge clock);
        @(posedge clock);
        #1;
        idle();
        exp_st("reset", 0, 0, 0, 0, 4'b0000);

        step(); alloc(0);                   exp_st("alloc0", 0, 0, 0, 0, 4'b0000);
        step(); alloc(1);                   exp_st("alloc1", 1, 0, 1, 0, 4'b0000);
        step(); alloc(2);                   exp_st("alloc2", 2, 0, 2, 0, 4'b0000);
        step(); alloc(3);                   exp_st("alloc3", 3, 0, 3, 0, 4'b0000);
        step(); alloc(4);                   exp_st("full4", 0, 1, 4, 0, 4'b0000);
        step(); resolve(1, 0);              exp_st("full_alloc_ignored", 0, 1, 4, 0, 4'b0000);
        step(); cdb_valid = 1; cdb_tag = 6'd37;
                                            exp_st("hole_still_full", 0, 1, 3, 0, 4'b0000);
        step(); resolve(0, 1);              exp_st("mp0_full", 0, 1, 3, 1, 4'b1111);
                                            exp_rs("mp0_cdb_prev", 0, 32'h0000_00FF, 4'b1111);
        step();                             exp_st("mp0_after", 0, 0, 0, 0, 4'b0000);

        step(); alloc(0);                   exp_st("re_alloc0", 0, 0, 0, 0, 4'b0000);
        step(); alloc(1);                   exp_st("re_alloc1", 1, 0, 1, 0, 4'b0000);
        step(); resolve(0, 1); cdb_valid = 1; cdb_tag = 6'd37;
                                            exp_st("mp0_samecyc", 2, 0, 2, 1, 4'b0011);
                                            exp_rs("mp0_cdb_fwd", 0, 32'h0000_00FF, 4'b0011);

        step(); alloc(0);                   exp_st("empty_alloc0", 0, 0, 0, 0, 4'b0000);
        step(); alloc(1);                   exp_st("alloc1_b", 1, 0, 1, 0, 4'b0000);
        step(); alloc(2);                   exp_st("alloc2_b", 2, 0, 2, 0, 4'b0000);
        step(); resolve(1, 1);              exp_st("mp1_mid", 3, 0, 3, 1, 4'b0110);
                                            exp_rs("mp1_restore", 1, snap_rdy(1), 4'b0110);
        step(); resolve(0, 0);              exp_st("mp1_after", 1, 0, 1, 0, 4'b0000);

        step(); alloc(1);                   exp_st("wrap_alloc1", 1, 0, 0, 0, 4'b0000);
        step(); alloc(2);                   exp_st("wrap_alloc2", 2, 0, 1, 0, 4'b0000);
        step(); alloc(3);                   exp_st("wrap_alloc3", 3, 0, 2, 0, 4'b0000);
        step(); alloc(0); resolve(1, 0);    exp_st("alloc_plus_resolve", 0, 0, 3, 0, 4'b0000);
        step(); resolve(2, 0);              exp_st("both_happened", 1, 0, 3, 0, 4'b0000);
        step(); resolve(3, 1);              exp_st("mp3_wrap", 1, 0, 2, 1, 4'b1001);
                                            exp_rs("mp3_restore", 3, snap_rdy(3), 4'b1001);
        step(); alloc(3);                   exp_st("wrap_after", 3, 0, 0, 0, 4'b0000);

        step(); alloc(0); resolve(3, 0);    exp_st("alloc0_res3", 0, 0, 1, 0, 4'b0000);
        step(); alloc(2); resolve(0, 1);    exp_st("alloc_with_mp", 1, 0, 1, 1, 4'b0001);
                                            exp_rs("mp0_alloc_drop", 0, snap_rdy(0), 4'b0001);
        step(); resolve(2, 1);              exp_st("alloc_dropped_invalid_mp", 0, 0, 0, 0, 4'b0000);

        step(); alloc(0);                   exp_st("rst_alloc0", 0, 0, 0, 0, 4'b0000);
        step(); alloc(1);                   exp_st("rst_alloc1", 1, 0, 1, 0, 4'b0000);
        step(); resolve(0, 1); reset = 1;   exp_st("mp_with_reset", 2, 0, 2, 1, 4'b0011);
                                            exp_rs("mp_reset_restore", 0, snap_rdy(0), 4'b0011);
        step();                             exp_st("after_reset", 0, 0, 0, 0, 4'b0000);

        step();
        step();
        done = 1;
    end

endmodule
